nibble_add_sequencer: RTL and testbench

NIBBLE_ADD_SEQUENCER -- requirements
Module: nibble_add_sequencer

---
 rtl/nibble_add_sequencer_if.sv | 25 ++
 rtl/nibble_add_sequencer.sv | 144 ++++++++++++++
 tb/tb_nibble_add_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/nibble_add_sequencer_if.sv
// nibble_add_sequencer_if
//   Handshake and data bundle for the nibble-serial add/subtract sequencer.
//   master : drives start, op_sub, a, b; observes busy, done, sum, cout, ovf
//   slave  : the sequencer side (inverse directions)
interface nibble_add_sequencer_if;
    logic        start;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer
//   16-bit add/subtract computed one nibble per cycle through a single
//   4-bit ripple adder. An accepted start is followed by 4 RUN cycles and a
//   single-cycle done pulse; results hold until the next accepted start.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_add_sequencer_if
//           (start, op_sub, a, b in; busy, done, sum, cout, ovf out)
//
//   state | meaning
//   IDLE  | waiting for start; results from the last operation held
//   RUN   | processing nibble idx_q (LSB first), 4 cycles
//   DONE  | result valid, done asserted; start here begins a new operation

module nibble_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module nibble_add_sequencer (
    input  logic                         clk,
    input  logic                         rst_n,
    nibble_add_sequencer_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] a_q, a_d;
    logic [15:0] bp_q, bp_d;        // B, or ~B for subtract
    logic        sub_q, sub_d;
    logic        carry_q, carry_d;  // adder carry from the previous nibble
    logic [15:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;

    logic [3:0]  nib_a, nib_b, nib_s;
    logic        nib_cin, nib_co;
    logic [3:0]  lsb;

    assign lsb     = {idx_q, 2'b00};
    assign nib_a   = a_q[lsb +: 4];
    assign nib_b   = bp_q[lsb +: 4];
    // Subtract is a + ~b + 1: the +1 enters as carry-in of nibble 0.
    assign nib_cin = (idx_q == 2'd0) ? sub_q : carry_q;

    nibble_adder4 u_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (nib_cin),
        .s    (nib_s),
        .cout (nib_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            a_q     <= 16'd0;
            bp_q    <= 16'd0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= 16'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            bp_q    <= bp_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        bp_d    = bp_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    bp_d    = bus.op_sub ? ~bus.b : bus.b;
                    sub_d   = bus.op_sub;
                    idx_d   = 2'd0;
                    carry_d = 1'b0;
                    sum_d   = 16'd0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[lsb +: 4] = nib_s;
                carry_d         = nib_co;
                idx_d           = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cout_d  = nib_co;
                    // nib_s[3] is the final sum[15]
                    ovf_d   = (a_q[15] == bp_q[15]) && (nib_s[3] != a_q[15]);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb_nibble_add_sequencer
//   Self-checking bench: directed vectors plus random operations compared
//   against an arithmetic reference model; back-to-back and mid-run reset.
module tb_nibble_add_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    nibble_add_sequencer_if bus ();

    nibble_add_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
        int ux, uy, sx, sy, r;
        logic [15:0] res;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            res = x - y;
            c   = (ux >= uy);
            r   = sx - sy;
        end else begin
            res = x + y;
            c   = ((ux + uy) > 65535);
            r   = sx + sy;
        end
        v = (r > 32767) || (r < -32768);
        return {v, c, res};
    endfunction

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sb,
                         input string tag);
        logic [17:0] e;
        e = model(av, bv, sb);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = av;
        bus.b      = bv;
        bus.op_sub = sb;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, " busy"}, 32'(bus.busy), 32'd1);
            check({tag, " done_in_run"}, 32'(bus.done), 32'd0);
            // Ignored while running: scramble start and operands.
            bus.start  = 1'($urandom);
            bus.a      = 16'($urandom);
            bus.b      = 16'($urandom);
            bus.op_sub = 1'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " busy_off"}, 32'(bus.busy), 32'd0);
        check({tag, " sum"}, 32'(bus.sum), 32'(e[15:0]));
        check({tag, " cout"}, 32'(bus.cout), 32'(e[16]));
        check({tag, " ovf"}, 32'(bus.ovf), 32'(e[17]));
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, " sum_hold"}, 32'(bus.sum), 32'(e[15:0]));
    endtask

    logic [15:0] qa [0:20];
    logic [15:0] qb [0:20];
    logic        qs [0:20];

    initial begin
        logic [17:0] e;
        bit seen_done;
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = 16'd0;
        bus.b      = 16'd0;
        #2;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);
        #10 rst_n = 1'b1;

        do_op(16'h1234, 16'h4321, 1'b0, "add_5555");
        do_op(16'hFFFF, 16'h0001, 1'b0, "add_carry");
        do_op(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        do_op(16'h0005, 16'h0007, 1'b0 | 1'b1, "sub_borrow");
        do_op(16'h8000, 16'h0001, 1'b1, "sub_ovf");
        do_op(16'h0000, 16'h8000, 1'b1, "sub_min");

        for (int i = 0; i < 20; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), "rand");

        // Back-to-back with start held high: accepts at edges 0, 5, 10, 15.
        for (int c = 0; c <= 20; c++) begin
            qa[c] = 16'($urandom);
            qb[c] = 16'($urandom);
            qs[c] = 1'($urandom);
        end
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = qa[0];
        bus.b      = qb[0];
        bus.op_sub = qs[0];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("b2b done", 32'(bus.done), (c % 5 == 4) ? 32'd1 : 32'd0);
            if (c % 5 == 4) begin
                e = model(qa[c-4], qb[c-4], qs[c-4]);
                check("b2b sum", 32'(bus.sum), 32'(e[15:0]));
                check("b2b cout", 32'(bus.cout), 32'(e[16]));
                check("b2b ovf", 32'(bus.ovf), 32'(e[17]));
            end
            bus.a      = qa[c+1];
            bus.b      = qb[c+1];
            bus.op_sub = qs[c+1];
            bus.start  = (c == 19) ? 1'b0 : 1'b1;
        end

        // Reset pulse during the 2nd RUN cycle.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = 16'h0007;
        bus.b      = 16'h0008;
        bus.op_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid busy", 32'(bus.busy), 32'd0);
        check("rst_mid done", 32'(bus.done), 32'd0);
        check("rst_mid sum", 32'(bus.sum), 32'd0);
        #1 rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("rst_mid no_done", 32'(seen_done), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
